// File: rtl/cix_pipe_if.sv
// cix_pipe handshake bundle: operand side (in_*) from issue, result side (out_*) to writeback.
interface cix_pipe_if #(
    parameter int unsigned ORDER = 3
);
    logic [2:0]            in_op;
    logic [(1<<ORDER)-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ORDER:0]        out_count;
    logic                  out_flag;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_op, in_data, in_valid, out_ready,
        input  in_ready, out_count, out_flag, out_valid
    );

    modport slave (
        input  in_op, in_data, in_valid, out_ready,
        output in_ready, out_count, out_flag, out_valid
    );
endinterface

// File: rtl/cix_pipe.sv
// cix_pipe: pipelined popcount / leading-zero / trailing-zero unit with elastic valid/ready stages.
// Define CIX_PIPE_PARITY_EN to enable kind 3 (parity); otherwise kind 3 returns 0/0.
module cix_pipe #(
    parameter int unsigned ORDER = 3
) (
    input  logic      clock,
    input  logic      reset_n,
    cix_pipe_if.slave io
);
    localparam int unsigned    W    = 1 << ORDER;
    localparam logic [ORDER:0] FULL = (ORDER+1)'(W);

    typedef enum logic [1:0] {
        CIX_PCNT = 2'd0,
        CIX_CLZ  = 2'd1,
        CIX_CTZ  = 2'd2,
        CIX_PAR  = 2'd3
    } cix_kind_e;

    logic           rdy_q;
    logic [ORDER:0] vld_q;
    logic [ORDER:0] load;
    cix_kind_e      kind_q [ORDER+1];
    cix_kind_e      in_kind;
    logic [W-1:0]   x_q;
    logic [W-1:0]   x_d;
    logic [ORDER:0] fin_cnt;
    logic           fin_z;

    assign in_kind = cix_kind_e'(io.in_op[1:0]);

    // CLZ is turned into CTZ by bit-reversing the operand on entry.
    always_comb begin
        logic [W-1:0] inv;
        inv = io.in_data ^ {W{io.in_op[2]}};
        x_d = inv;
        if (in_kind == CIX_CLZ) begin
            for (int unsigned b = 0; b < W; b++) begin
                x_d[b] = inv[W-1-b];
            end
        end
    end

    // A stage may load if any stage from it to the output is empty, or the output drains.
    always_comb begin
        logic downstream_full;
        downstream_full = 1'b1;
        load            = '0;
        for (int unsigned k = ORDER + 1; k > 0; k--) begin
            downstream_full = downstream_full & vld_q[k-1];
            load[k-1]       = io.out_ready | ~downstream_full;
        end
    end

    assign io.in_ready  = rdy_q & load[0];
    assign io.out_valid = vld_q[ORDER];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q <= 1'b0;
            vld_q <= '0;
            x_q   <= '0;
            for (int unsigned k = 0; k <= ORDER; k++) begin
                kind_q[k] <= CIX_PCNT;
            end
        end else begin
            rdy_q <= 1'b1;
            if (io.in_ready) begin
                vld_q[0] <= io.in_valid;
                if (io.in_valid) begin
                    x_q       <= x_d;
                    kind_q[0] <= in_kind;
                end
            end
            for (int unsigned k = 1; k <= ORDER; k++) begin
                if (load[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        kind_q[k] <= kind_q[k-1];
                    end
                end
            end
        end
    end

    for (genvar lv = 0; lv <= ORDER; lv++) begin : g_lvl
        localparam int unsigned N = W >> lv;
        logic [lv:0] cnt [N];
        logic        z   [N];

        if (lv == 0) begin : g_leaf
            always_comb begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (kind_q[0] == CIX_CTZ || kind_q[0] == CIX_CLZ) begin
                        cnt[j] = ~x_q[j];
                    end else begin
                        cnt[j] = x_q[j];
                    end
                    z[j] = ~x_q[j];
                end
            end
        end else begin : g_node
            logic [lv:0] cnt_d [N];
            logic        z_d   [N];

            // An all-zero low half already counts its full width, so lo+hi gives 2^(lv-1)+hi.
            always_comb begin
                logic [lv:0] lo;
                logic [lv:0] hi;
                for (int unsigned j = 0; j < N; j++) begin
                    lo = {1'b0, g_lvl[lv-1].cnt[2*j]};
                    hi = {1'b0, g_lvl[lv-1].cnt[2*j+1]};
                    if (kind_q[lv-1] == CIX_CTZ || kind_q[lv-1] == CIX_CLZ) begin
                        cnt_d[j] = g_lvl[lv-1].z[2*j] ? lo + hi : lo;
                        z_d[j]   = g_lvl[lv-1].z[2*j] & g_lvl[lv-1].z[2*j+1];
                    end else begin
                        cnt_d[j] = lo + hi;
                        z_d[j]   = 1'b0;
                    end
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned j = 0; j < N; j++) begin
                        cnt[j] <= '0;
                        z[j]   <= 1'b0;
                    end
                end else if (load[lv] && vld_q[lv-1]) begin
                    for (int unsigned j = 0; j < N; j++) begin
                        cnt[j] <= cnt_d[j];
                        z[j]   <= z_d[j];
                    end
                end
            end
        end
    end

    assign fin_cnt = g_lvl[ORDER].cnt[0];
    assign fin_z   = g_lvl[ORDER].z[0];

    always_comb begin
        io.out_count = fin_cnt;
        io.out_flag  = 1'b0;
        unique case (kind_q[ORDER])
            CIX_PCNT:         io.out_flag = (fin_cnt == FULL);
            CIX_CLZ, CIX_CTZ: io.out_flag = fin_z;
            CIX_PAR: begin
`ifdef CIX_PIPE_PARITY_EN
                io.out_count = (ORDER+1)'(fin_cnt[0]);
                io.out_flag  = fin_cnt[0];
`else
                io.out_count = '0;
`endif
            end
        endcase
    end
endmodule

// File: tb/tb_cix_pipe.sv
// Directed bench for cix_pipe (ORDER=3): spot vectors, exhaustive stream, back-pressure, mid-stream reset.
module tb_cix_pipe;
    logic clock;
    logic reset_n;
    logic bp_en;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    int unsigned n_out = 0;

    logic [4:0] sb [$];
    logic       prev_stall = 1'b0;
    logic [3:0] prev_cnt   = '0;
    logic       prev_flag  = 1'b0;

    cix_pipe_if #(.ORDER(3)) bus ();

    cix_pipe #(.ORDER(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: result packed as {count[3:0], flag}.
    function automatic logic [4:0] ref_res(input logic [2:0] op, input logic [7:0] d);
        logic [7:0]  x;
        int unsigned pc, lz, tz;
        logic        seen;
        x  = op[2] ? ~d : d;
        pc = 0;
        for (int i = 0; i < 8; i++) pc += int'(x[i]);
        tz = 0; seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) seen = 1'b1;
            else if (!seen) tz++;
        end
        lz = 0; seen = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (x[i]) seen = 1'b1;
            else if (!seen) lz++;
        end
        case (op[1:0])
            2'd0:    return {4'(pc), pc == 8};
            2'd1:    return {4'(lz), lz == 8};
            2'd2:    return {4'(tz), tz == 8};
`ifdef CIX_PIPE_PARITY_EN
            default: return {4'(pc % 2), (pc % 2) == 1};
`else
            default: return 5'd0;
`endif
        endcase
    endfunction

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    always @(negedge clock) begin
        logic [4:0] e;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(bus.out_valid), 1);
                check("hold_count", int'(bus.out_count), int'(prev_cnt));
                check("hold_flag", int'(bus.out_flag), int'(prev_flag));
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_count", int'(bus.out_count), int'(e[4:1]));
                    check("sb_flag", int'(bus.out_flag), int'(e[0]));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_cnt   = bus.out_count;
            prev_flag  = bus.out_flag;
            if (bus.in_valid && bus.in_ready) sb.push_back(ref_res(bus.in_op, bus.in_data));
        end
    end

    initial begin
        bp_en = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] d);
        int unsigned guard = 0;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge clock);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) check("send_timeout", 0, 1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [2:0] op, input logic [7:0] d,
                           input int exp_cnt, input int exp_flag);
        int unsigned lat = 0;
        send(op, d);
        while (!bus.out_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, "_lat"}, int'(lat), 3);
        check({tag, "_cnt"}, int'(bus.out_count), exp_cnt);
        check({tag, "_flag"}, int'(bus.out_flag), exp_flag);
    endtask

    task automatic drain(input string tag);
        int unsigned g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clock);
            #1;
            g++;
        end
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        int unsigned start;
        int unsigned outs0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state and in_ready release timing.
        #3;
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_count", int'(bus.out_count), 0);
        check("rst_out_flag", int'(bus.out_flag), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rdy_before_edge", int'(bus.in_ready), 0);
        @(posedge clock);
        #1;
        check("rdy_after_edge", int'(bus.in_ready), 1);

        // Directed spot vectors: op = {invert, kind}.
        run_vec("pcnt_ff", 3'd0, 8'hFF, 8, 1);
        run_vec("clz_00", 3'd1, 8'h00, 8, 1);
        run_vec("ctz_08", 3'd2, 8'h08, 3, 0);
        run_vec("clzinv_f0", 3'd5, 8'hF0, 4, 0);
        run_vec("pcnt_5a", 3'd0, 8'h5A, 4, 0);
        run_vec("ctz_00", 3'd2, 8'h00, 8, 1);
        run_vec("clz_80", 3'd1, 8'h80, 0, 0);
        run_vec("clz_01", 3'd1, 8'h01, 7, 0);
        run_vec("ctzinv_ff", 3'd6, 8'hFF, 8, 1);
        run_vec("pcntinv_0f", 3'd4, 8'h0F, 4, 0);
`ifdef CIX_PIPE_PARITY_EN
        run_vec("par_07", 3'd3, 8'h07, 1, 1);
        run_vec("par_03", 3'd3, 8'h03, 0, 0);
        run_vec("parinv_07", 3'd7, 8'h07, 1, 1);
`else
        run_vec("par_07", 3'd3, 8'h07, 0, 0);
        run_vec("par_03", 3'd3, 8'h03, 0, 0);
        run_vec("parinv_07", 3'd7, 8'h07, 0, 0);
`endif
        drain("spot");

        // Exhaustive back-to-back stream, one accept per cycle.
        for (int op = 0; op < 8; op++) begin
            start = cyc;
            for (int d = 0; d < 256; d++) send(3'(op), 8'(d));
            check("throughput", int'(cyc - start), 256);
        end
        drain("exhaustive");

        // Back-pressure: fill all four stages, then stream the rest with random stalls.
        outs0         = n_out;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(3'd2, 8'(1 << k));
        @(negedge clock);
        check("full_in_ready", int'(bus.in_ready), 0);
        check("full_out_valid", int'(bus.out_valid), 1);
        check("full_head_count", int'(bus.out_count), 0);
        repeat (3) @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("head_frees_slot", int'(bus.in_ready), 1);
        @(posedge clock);
        #1;
        bp_en = 1'b1;
        for (int k = 4; k < 8; k++) send(3'd2, 8'(1 << k));
        drain("backpressure");
        bp_en = 1'b0;
        @(posedge clock);
        #2;
        bus.out_ready = 1'b1;
        check("bp_out_total", int'(n_out - outs0), 8);

        // Mid-stream reset with results in flight.
        for (int k = 0; k < 4; k++) send(3'd0, 8'((8'hFF) >> (2 * k)));
        check("inflight_valid", int'(bus.out_valid), 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_count", int'(bus.out_count), 0);
        check("midrst_in_ready", int'(bus.in_ready), 0);
        sb.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        run_vec("post_reset", 3'd0, 8'hAA, 4, 0);
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        check("watchdog", 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
